// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset while idle, runs it on a host req edge,
// bounds run length with a cycle counter, and arbitrates the data-memory port.
module run_ctrl #(
    parameter int            AW      = 8,
    parameter int            DW      = 8,
    parameter int            CW      = 16,
    parameter logic [CW-1:0] MAX_CYC = 16'd60000,
    parameter int            RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cyc_cnt
);
    localparam int            RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_FIN, S_TMO} state_t;

    state_t        state, state_d;
    logic          req_q;
    logic [RW-1:0] rst_cnt, rst_cnt_d;
    logic [CW-1:0] cyc_cnt_d;
    logic          start;

    // req_q resets high so a req already asserted at reset release is not an edge
    assign start = req & ~req_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            req_q   <= 1'b1;
            rst_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_d;
            req_q   <= req;
            rst_cnt <= rst_cnt_d;
            cyc_cnt <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        cyc_cnt_d = cyc_cnt;
        case (state)
            S_IDLE, S_FIN, S_TMO: begin
                if (start) begin
                    state_d   = S_RST;
                    rst_cnt_d = RST_LOAD;
                    cyc_cnt_d = '0;
                end
            end
            S_RST: begin
                if (rst_cnt == '0) state_d = S_RUN;
                else               rst_cnt_d = rst_cnt - RW'(1);
            end
            S_RUN: begin
                // core_done takes priority over the timeout check
                if (core_done)               state_d = S_FIN;
                else if (cyc_cnt == MAX_CYC) state_d = S_TMO;
                else                         cyc_cnt_d = cyc_cnt + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst   = (state != S_RUN);
    assign busy       = (state == S_RST) || (state == S_RUN);
    assign done       = (state == S_FIN);
    assign timeout    = (state == S_TMO);
    assign host_rdata = mem_rdata;

    // RST blocks both masters so nothing writes while the core is being reset
    always_comb begin
        host_gnt = 1'b0;
        mem_we   = 1'b0;
        mem_addr = host_addr;
        mem_din  = host_wdata;
        case (state)
            S_RUN: begin
                mem_we   = core_we;
                mem_addr = core_addr;
                mem_din  = core_wdata;
            end
            S_IDLE, S_FIN, S_TMO: begin
                host_gnt = host_req;
                mem_we   = host_req & host_we;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default instance plus a MAX_CYC=5 instance sharing inputs.
module tb_run_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       req, core_done, core_we, host_req, host_we;
    logic [7:0] core_addr, core_wdata, host_addr, host_wdata, mem_rdata;

    logic        host_gnt, mem_we, core_rst, busy, done, timeout;
    logic [7:0]  host_rdata, mem_addr, mem_din;
    logic [15:0] cyc_cnt;

    logic        t_host_gnt, t_mem_we, t_core_rst, t_busy, t_done, t_timeout;
    logic [7:0]  t_host_rdata, t_mem_addr, t_mem_din;
    logic [15:0] t_cyc_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256] = '{default: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_rdata = mem[mem_addr];

    run_ctrl u_dut (
        .clk(clk), .reset(reset), .req(req), .core_done(core_done),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .mem_rdata(mem_rdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .core_rst(core_rst),
        .busy(busy), .done(done), .timeout(timeout), .cyc_cnt(cyc_cnt)
    );

    run_ctrl #(.MAX_CYC(16'd5)) u_tmo (
        .clk(clk), .reset(reset), .req(req), .core_done(core_done),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .mem_rdata(mem_rdata),
        .host_gnt(t_host_gnt), .host_rdata(t_host_rdata), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_din(t_mem_din), .core_rst(t_core_rst),
        .busy(t_busy), .done(t_done), .timeout(t_timeout), .cyc_cnt(t_cyc_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first RUN cycle (RST_CYC=2).
    task automatic start_run();
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b1; core_done = 1'b0; core_we = 1'b0;
        core_addr = 8'h00; core_wdata = 8'h00;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        tick(); tick();
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: rst=%b busy=%b done=%b tmo=%b, want 1 0 0 0", core_rst, busy, done, timeout);
        end
        checks++;
        if (cyc_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cyc: got %0d want 0", cyc_cnt);
        end
        checks++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: gnt=%b we=%b want 1 0", host_gnt, mem_we);
        end
        host_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || core_rst !== 1'b1) begin
                errors++; $display("FAIL req_high_no_start: cyc %0d busy=%b rst=%b want 0 1", i, busy, core_rst);
            end
        end
    endtask

    task automatic test_host_mem();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_din !== 8'h5A) begin
            errors++;
            $display("FAIL host_write: gnt=%b we=%b addr=%h din=%h want 1 1 10 5a", host_gnt, mem_we, mem_addr, mem_din);
        end
        tick();
        host_we = 1'b0;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || mem_we !== 1'b0 || host_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL host_read: gnt=%b we=%b rdata=%h want 1 0 5a", host_gnt, mem_we, host_rdata);
        end
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_run_done();
        req = 1'b0;
        tick();
        req = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || host_rdata !== 8'h5A) begin
            errors++; $display("FAIL start_same_cycle_host: gnt=%b rdata=%h want 1 5a", host_gnt, host_rdata);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || core_rst !== 1'b1) begin
            errors++; $display("FAIL rst_entry: busy=%b rst=%b want 1 1", busy, core_rst);
        end
        host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h11;
        core_we = 1'b1; core_addr = 8'h31; core_wdata = 8'h22;
        #1;
        checks++;
        if (mem_we !== 1'b0 || host_gnt !== 1'b0) begin
            errors++; $display("FAIL rst_block: we=%b gnt=%b want 0 0", mem_we, host_gnt);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || core_rst !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_second: busy=%b rst=%b we=%b want 1 1 0", busy, core_rst, mem_we);
        end
        host_req = 1'b0; host_we = 1'b0; core_we = 1'b0;
        tick();
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b1 || cyc_cnt !== 16'd0) begin
            errors++; $display("FAIL run_entry: rst=%b busy=%b cyc=%0d want 0 1 0", core_rst, busy, cyc_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'hC3;
                host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h11;
                #1;
                checks++;
                if (host_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_din !== 8'hC3) begin
                    errors++;
                    $display("FAIL run_mux: gnt=%b we=%b addr=%h din=%h want 0 1 20 c3", host_gnt, mem_we, mem_addr, mem_din);
                end
            end
            if (i == 4) begin
                core_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
            end
            tick();
        end
        checks++;
        if (cyc_cnt !== 16'd20 || core_rst !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL run_20: cyc=%0d rst=%b done=%b want 20 0 0", cyc_cnt, core_rst, done);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || cyc_cnt !== 16'd20 || core_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fin: done=%b tmo=%b cyc=%0d rst=%b busy=%b want 1 0 20 1 0", done, timeout, cyc_cnt, core_rst, busy);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || host_rdata !== 8'hC3) begin
            errors++; $display("FAIL core_write_landed: gnt=%b rdata=%h want 1 c3", host_gnt, host_rdata);
        end
        host_addr = 8'h30;
        #1;
        checks++;
        if (host_rdata !== 8'h00) begin
            errors++; $display("FAIL blocked_writes: rdata=%h want 00", host_rdata);
        end
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        start_run();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req = 1'b0;
            if (i == 2) req = 1'b1;
            tick();
        end
        checks++;
        if (t_busy !== 1'b1 || t_timeout !== 1'b0 || t_cyc_cnt !== 16'd5) begin
            errors++; $display("FAIL tmo_pre: busy=%b tmo=%b cyc=%0d want 1 0 5", t_busy, t_timeout, t_cyc_cnt);
        end
        tick();
        checks++;
        if (t_timeout !== 1'b1 || t_done !== 1'b0 || t_cyc_cnt !== 16'd5 || t_core_rst !== 1'b1) begin
            errors++;
            $display("FAIL tmo: tmo=%b done=%b cyc=%0d rst=%b want 1 0 5 1", t_timeout, t_done, t_cyc_cnt, t_core_rst);
        end
        tick(); tick(); tick();
        checks++;
        if (t_timeout !== 1'b1 || t_cyc_cnt !== 16'd5) begin
            errors++; $display("FAIL tmo_hold: tmo=%b cyc=%0d want 1 5", t_timeout, t_cyc_cnt);
        end
        start_run();
        checks++;
        if (t_timeout !== 1'b0 || t_busy !== 1'b1 || t_cyc_cnt !== 16'd0) begin
            errors++; $display("FAIL tmo_restart: tmo=%b busy=%b cyc=%0d want 0 1 0", t_timeout, t_busy, t_cyc_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (t_done !== 1'b1 || t_timeout !== 1'b0 || t_cyc_cnt !== 16'd5) begin
            errors++; $display("FAIL done_beats_tmo: done=%b tmo=%b cyc=%0d want 1 0 5", t_done, t_timeout, t_cyc_cnt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        start_run();
        tick(); tick(); tick();
        checks++;
        if (cyc_cnt !== 16'd3 || core_rst !== 1'b0) begin
            errors++; $display("FAIL pre_areset: cyc=%0d rst=%b want 3 0", cyc_cnt, core_rst);
        end
        core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h77;
        #1;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++; $display("FAIL core_we_pass: we=%b want 1", mem_we);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0 || cyc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL areset_now: we=%b rst=%b busy=%b cyc=%0d want 0 1 0 0", mem_we, core_rst, busy, cyc_cnt);
        end
        tick();
        core_we = 1'b0;
        reset = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || cyc_cnt !== 16'd0 || done !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL areset_after: busy=%b cyc=%0d done=%b rst=%b want 0 0 0 1", busy, cyc_cnt, done, core_rst);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        #1;
        checks++;
        if (host_rdata !== 8'h00) begin
            errors++; $display("FAIL dropped_write: rdata=%h want 00", host_rdata);
        end
        host_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_host_mem();
        test_run_done();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
